// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving a CPU port and a loader port shared access to one data memory.
// One transaction at a time runs through IDLE -> ISSUE -> WAIT -> DONE, so done follows gnt by MEM_LAT+1 cycles.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                last_l;
  logic                win_l_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   c_rdata_q, l_rdata_q;
  logic                pick_c, pick_l;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pick_c    = 1'b0;
    pick_l    = 1'b0;
    case (state)
      IDLE: begin
        if (c_req || l_req) begin
          // On a tie the port that was not granted last time wins.
          pick_l    = l_req && (!c_req || !last_l);
          pick_c    = !pick_l;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = LAT_M1;
        state_nxt = (MEM_LAT > 1) ? WAIT : DONE;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last_l    <= 1'b1;
      win_l_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pick_c || pick_l) begin
        last_l  <= pick_l;
        win_l_q <= pick_l;
        we_q    <= pick_l ? l_we    : c_we;
        addr_q  <= pick_l ? l_addr  : c_addr;
        wdata_q <= pick_l ? l_wdata : c_wdata;
      end
      if (state == DONE && !we_q) begin
        if (win_l_q) l_rdata_q <= mem_rdata;
        else         c_rdata_q <= mem_rdata;
      end
    end
  end

  // Pulses are gated by rst so nothing escapes during the reset cycle itself.
  assign c_gnt     = pick_c && !rst;
  assign l_gnt     = pick_l && !rst;
  assign c_done    = (state == DONE) && !win_l_q && !rst;
  assign l_done    = (state == DONE) &&  win_l_q && !rst;
  assign mem_re    = (state == ISSUE) && !we_q && !rst;
  assign mem_we    = (state == ISSUE) &&  we_q && !rst;
  assign busy      = (state != IDLE) && !rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign c_rdata   = c_rdata_q;
  assign l_rdata   = l_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with MEM_LAT=3: arbitration, latency, read/write, busy blocking, reset abort.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_gnt, c_done;
  logic [31:0] c_rdata;
  logic        l_req = 1'b0, l_we = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic        l_gnt, l_done;
  logic [31:0] l_rdata;
  logic        mem_re, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h1111_0000;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    c_req = 1'b1;
    #1;
    n_total++; if (c_gnt !== 1'b0) $display("FAIL rst_gnt_gated: c_gnt=%b exp 0", c_gnt); else n_pass++;
    c_req = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_total++; if ({mem_re, mem_we} !== 2'b00) $display("FAIL rst_mem_cmd: got %b exp 00", {mem_re, mem_we}); else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); else n_pass++;
    n_total++; if (c_rdata !== 32'h0) $display("FAIL rst_c_rdata: got %h exp 0", c_rdata); else n_pass++;
    n_total++; if (l_rdata !== 32'h0) $display("FAIL rst_l_rdata: got %h exp 0", l_rdata); else n_pass++;
    n_total++; if ({c_done, l_done} !== 2'b00) $display("FAIL rst_done: got %b exp 00", {c_done, l_done}); else n_pass++;
  endtask

  task automatic test_round_robin();
    cyc();
    c_req = 1'b1; l_req = 1'b1; c_we = 1'b0; l_we = 1'b0;
    c_addr = 32'h4; l_addr = 32'h8;
    #1;
    n_total++; if ({c_gnt, l_gnt} !== 2'b10) $display("FAIL rr_tie1: gnt c,l=%b exp 10", {c_gnt, l_gnt}); else n_pass++;
    cyc();
    c_req = 1'b0;
    #1;
    n_total++; if (busy !== 1'b1 || l_gnt !== 1'b0) $display("FAIL rr_busy1: busy=%b l_gnt=%b exp 1,0", busy, l_gnt); else n_pass++;
    n_total++; if (mem_addr !== 32'h4) $display("FAIL rr_addr1: got %h exp 4", mem_addr); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      if (c_done === 1'b1) break;
      cyc();
    end
    n_total++; if (c_done !== 1'b1) $display("FAIL rr_cdone: c_done=%b exp 1 within bound", c_done); else n_pass++;
    cyc();
    n_total++; if ({c_gnt, l_gnt} !== 2'b01) $display("FAIL rr_tie2: gnt c,l=%b exp 01", {c_gnt, l_gnt}); else n_pass++;
    n_total++; if (c_rdata !== 32'h1111_0000) $display("FAIL rr_c_rdata: got %h exp 11110000", c_rdata); else n_pass++;
    cyc();
    l_req = 1'b0;
    #1;
    n_total++; if (mem_addr !== 32'h8) $display("FAIL rr_addr2: got %h exp 8", mem_addr); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      if (l_done === 1'b1) break;
      cyc();
    end
    n_total++; if (l_done !== 1'b1) $display("FAIL rr_ldone: l_done=%b exp 1 within bound", l_done); else n_pass++;
    cyc();
    c_req = 1'b1; l_req = 1'b1;
    #1;
    n_total++; if ({c_gnt, l_gnt} !== 2'b10) $display("FAIL rr_tie3: gnt c,l=%b exp 10", {c_gnt, l_gnt}); else n_pass++;
    cyc();
    c_req = 1'b0; l_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (c_done === 1'b1) break;
      cyc();
    end
    n_total++; if (c_done !== 1'b1) $display("FAIL rr_cdone3: c_done=%b exp 1 within bound", c_done); else n_pass++;
    cyc();
    n_total++; if (l_rdata !== 32'h1111_0000) $display("FAIL rr_l_rdata: got %h exp 11110000", l_rdata); else n_pass++;
  endtask

  task automatic test_busy_blocks();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h50; l_wdata = 32'h5;
    #1;
    n_total++; if (l_gnt !== 1'b1) $display("FAIL busy_lgnt: got %b exp 1", l_gnt); else n_pass++;
    cyc();
    l_req = 1'b0;
    #1;
    n_total++; if (mem_we !== 1'b1) $display("FAIL busy_memwe: got %b exp 1", mem_we); else n_pass++;
    cyc();
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h60; c_wdata = 32'h6;
    #1;
    n_total++; if (c_gnt !== 1'b0 || busy !== 1'b1) $display("FAIL busy_wait1: c_gnt=%b busy=%b exp 0,1", c_gnt, busy); else n_pass++;
    cyc();
    n_total++; if (c_gnt !== 1'b0 || busy !== 1'b1) $display("FAIL busy_wait2: c_gnt=%b busy=%b exp 0,1", c_gnt, busy); else n_pass++;
    cyc();
    n_total++; if (l_done !== 1'b1 || c_gnt !== 1'b0 || busy !== 1'b1) $display("FAIL busy_done: l_done=%b c_gnt=%b busy=%b exp 1,0,1", l_done, c_gnt, busy); else n_pass++;
    cyc();
    n_total++; if (c_gnt !== 1'b1 || busy !== 1'b0) $display("FAIL busy_idle_gnt: c_gnt=%b busy=%b exp 1,0", c_gnt, busy); else n_pass++;
    cyc();
    c_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (c_done === 1'b1) break;
      cyc();
    end
    n_total++; if (c_done !== 1'b1) $display("FAIL busy_cdone: c_done=%b exp 1 within bound", c_done); else n_pass++;
    cyc();
    n_total++; if (l_rdata !== 32'h1111_0000) $display("FAIL busy_l_rdata: got %h exp 11110000", l_rdata); else n_pass++;
  endtask

  task automatic test_read_latency();
    mem_rdata = 32'h0BAD_0BAD;
    cyc();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    #1;
    n_total++; if (c_gnt !== 1'b1) $display("FAIL rd_gnt: got %b exp 1", c_gnt); else n_pass++;
    cyc();
    c_req = 1'b0; c_addr = 32'h44;
    #1;
    n_total++; if ({mem_re, mem_we} !== 2'b10) $display("FAIL rd_issue: re,we=%b exp 10", {mem_re, mem_we}); else n_pass++;
    n_total++; if (mem_addr !== 32'h10) $display("FAIL rd_addr_held: got %h exp 10", mem_addr); else n_pass++;
    cyc();
    n_total++; if (mem_re !== 1'b0 || c_done !== 1'b0) $display("FAIL rd_wait1: re=%b done=%b exp 0,0", mem_re, c_done); else n_pass++;
    cyc();
    n_total++; if (c_done !== 1'b0 || mem_addr !== 32'h10) $display("FAIL rd_wait2: done=%b addr=%h exp 0,10", c_done, mem_addr); else n_pass++;
    cyc();
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if ({c_done, l_done} !== 2'b10) $display("FAIL rd_done: c,l done=%b exp 10", {c_done, l_done}); else n_pass++;
    cyc();
    mem_rdata = 32'h0BAD_0BAD;
    #1;
    n_total++; if (c_done !== 1'b0 || busy !== 1'b0) $display("FAIL rd_after: done=%b busy=%b exp 0,0", c_done, busy); else n_pass++;
    n_total++; if (c_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h exp deadbeef", c_rdata); else n_pass++;
  endtask

  task automatic test_loader_write();
    cyc();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'h1234_5678;
    #1;
    n_total++; if (l_gnt !== 1'b1) $display("FAIL wr_gnt: got %b exp 1", l_gnt); else n_pass++;
    cyc();
    l_req = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
    #1;
    n_total++; if ({mem_re, mem_we} !== 2'b01) $display("FAIL wr_issue: re,we=%b exp 01", {mem_re, mem_we}); else n_pass++;
    n_total++; if (mem_addr !== 32'h20 || mem_wdata !== 32'h1234_5678) $display("FAIL wr_cmd: addr=%h wdata=%h exp 20,12345678", mem_addr, mem_wdata); else n_pass++;
    cyc();
    n_total++; if ({mem_re, mem_we} !== 2'b00) $display("FAIL wr_wait: re,we=%b exp 00", {mem_re, mem_we}); else n_pass++;
    cyc();
    cyc();
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if (l_done !== 1'b1 || mem_re !== 1'b0) $display("FAIL wr_done: l_done=%b re=%b exp 1,0", l_done, mem_re); else n_pass++;
    cyc();
    mem_rdata = 32'h0BAD_0BAD;
    #1;
    n_total++; if (l_rdata !== 32'h1111_0000) $display("FAIL wr_l_rdata: got %h exp 11110000", l_rdata); else n_pass++;
  endtask

  task automatic test_reset_abort();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h30;
    #1;
    n_total++; if (c_gnt !== 1'b1) $display("FAIL ab_gnt: got %b exp 1", c_gnt); else n_pass++;
    n_total++; if (c_rdata !== 32'h0 || mem_addr !== 32'h0) $display("FAIL ab_cleared: rdata=%h addr=%h exp 0,0", c_rdata, mem_addr); else n_pass++;
    cyc();
    c_req = 1'b0;
    cyc();
    rst = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if (c_done !== 1'b0 || busy !== 1'b0) $display("FAIL ab_in_rst: done=%b busy=%b exp 0,0", c_done, busy); else n_pass++;
    cyc();
    rst = 1'b0;
    #1;
    n_total++; if ({busy, mem_re, mem_we, c_done} !== 4'b0000) $display("FAIL ab_after: busy,re,we,done=%b exp 0000", {busy, mem_re, mem_we, c_done}); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_total++; if (c_done !== 1'b0) $display("FAIL ab_no_done: c_done=%b exp 0 (cycle %0d)", c_done, k); else n_pass++;
    end
    n_total++; if (c_rdata !== 32'h0) $display("FAIL ab_rdata: got %h exp 0", c_rdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_busy_blocks();
    test_read_latency();
    test_loader_write();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
